instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Multicycle fetch sequencer that produces the instruction word and PC consumed by the PC/IR capture register in the RISC-V 32I multicycle core. It owns the architectural PC and runs a request/ready handshake with instruction memory. It delivers each fetched word with a one-cycle `IRWrite` pulse, and it reports misaligned-PC and memory-timeout faults to the control FSM.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded by reset.
- `TIMEOUT_CYCLES`, default 255: maximum number of REQ cycles before timeout; the legal range is 1..1023.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `fetch_start`  in  1  control FSM requests a fetch at the current PC.
- `PCWrite`  in  1  load `PCNext` into the PC.
- `PCNext`  in  32  next PC value from the ALU/result mux.
- `imem_req`  out  1  memory request; held until the memory accepts it.
- `imem_addr`  out  32  fetch address; equals `PC` at all times.
- `imem_ready`  in  1  memory response valid; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32  instruction word from memory.
- `PC`  out  32  architectural PC; feeds the capture register's `PC` input.
- `Instr`  out  32  last fetched word; feeds `in_Instr`.
- `IRWrite`  out  1  one-cycle strobe: `Instr` is new this cycle.
- `fetch_busy`  out  1  high in the REQ and DONE states.
- `fetch_fault`  out  1  high in the FAULT state.
- `fault_cause`  out  1  0 = misaligned PC, 1 = timeout; valid while `fetch_fault` is high.

## Operation
- States: IDLE, REQ, DONE, FAULT.
- **IDLE**
  - `fetch_start` with `PC[1:0]==0` goes to REQ.
  - `fetch_start` with `PC[1:0]!=0` goes to FAULT with cause 0. No request is issued.
- **REQ**
  - `imem_req` is 1.
  - `imem_ready`=1 captures `imem_rdata` into `Instr` and goes to DONE.
  - Otherwise the watchdog increments. When it reaches `TIMEOUT_CYCLES`, the unit goes to FAULT with cause 1 and drops `imem_req`.
- **DONE**
  - `IRWrite` is 1 for exactly this cycle.
  - Next state is IDLE unconditionally.
- **FAULT**
  - Sticky.
  - `PCWrite` loads the PC and goes to IDLE.
  - `fetch_start` is ignored.
  - `imem_ready` is ignored.
- **PC update**
  - `PCWrite` in IDLE or FAULT updates the PC at the next edge.
  - `PCWrite` in REQ or DONE is buffered in a one-entry pending register (value plus valid bit). The PC must stay stable while a request is outstanding.
  - The pending value is applied on the DONE→IDLE or REQ→FAULT edge.
  - A second `PCWrite` while the pending entry is valid overwrites it (last write wins).
- **Ignored inputs:** `fetch_start` in REQ or DONE is ignored, and no request is queued.
- `imem_ready` outside REQ is ignored; `Instr` is unchanged.
- The watchdog clears on every entry to REQ. Its width is `$clog2(TIMEOUT_CYCLES+1)`.

## Timing
- **Reset values:**
  - `PC` = `imem_addr` = `RESET_PC`.
  - `Instr` = 32'h0000_0013 (NOP).
  - `IRWrite` = `imem_req` = `fetch_busy` = `fetch_fault` = `fault_cause` = 0.
  - State is IDLE; the pending entry is invalid.
- `fetch_start` in cycle 0 → `imem_req` high from cycle 1.
- `imem_ready` in cycle k → `IRWrite` and the new `Instr` in cycle k+1.
- The minimum fetch is 3 cycles: start, REQ with same-cycle ready, DONE.
- **Simultaneous events in IDLE:**
  - `PCWrite` and `fetch_start` together: the PC updates first, and alignment is checked against `PCNext`. REQ uses the new PC.
  - Alignment is therefore checked on the effective address: `PCNext` when `PCWrite` is set, else `PC`.
- `imem_ready` in the same cycle the watchdog reaches its limit: ready wins, and the state goes to DONE.
- **Reset mid-operation:** all state returns to reset values immediately.
  - `imem_req` drops asynchronously.
  - A late `imem_ready` after reset is ignored.
- `Instr` holds its value between fetches. Only `IRWrite` marks it new.

## Structure
- Package `fetch_pkg`:
  - `typedef enum logic [1:0] {F_IDLE, F_REQ, F_DONE, F_FAULT} fetch_state_t`
  - `localparam logic [31:0] NOP_INSTR = 32'h0000_0013`
  - `localparam logic FAULT_MISALIGN = 1'b0`, `FAULT_TIMEOUT = 1'b1`
- One sub-module, `fetch_watchdog`: a clear/enable up-counter with a terminal-count output, parameterised by `TIMEOUT_CYCLES`.
- The FSM, PC register, pending-PC buffer and `Instr` register live in the top.

## Test plan
- **Basic fetch:** reset, then `fetch_start`; memory returns 32'h00500093 with ready 2 cycles after the request → `imem_addr`=0, `IRWrite` high once, `Instr`=32'h00500093; `PC` stays 0.
- **Same-cycle update and start:** `PCWrite`=1, `PCNext`=32'h40, and `fetch_start` in the same IDLE cycle → `imem_addr`=32'h40 on the first `imem_req` cycle.
- **Misaligned PC:** `PCNext`=32'h42 with `PCWrite`, then `fetch_start` → no `imem_req`, `fetch_fault`=1, `fault_cause`=0. Then `PCWrite` with 32'h44 → IDLE, fault clears.
- **Timeout:** `TIMEOUT_CYCLES`=4 and `imem_ready` held low → `imem_req` high for exactly 4 cycles, then `fetch_fault`=1, `fault_cause`=1; a later `imem_ready` leaves `Instr` unchanged.
- **Deferred PC write:** `PCWrite` with 32'h80 during REQ → `imem_addr` stays at the old PC until DONE; `PC`=32'h80 in the IDLE cycle after DONE.
- **Reset mid-request:** assert `reset_n`=0 during REQ → `imem_req` is 0 within the same cycle; `PC`=`RESET_PC` and `Instr`=32'h00000013.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the multicycle instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {F_IDLE, F_REQ, F_DONE, F_FAULT} fetch_state_t;

  localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
  localparam logic        FAULT_MISALIGN = 1'b0;
  localparam logic        FAULT_TIMEOUT  = 1'b1;

  function automatic logic is_aligned(input logic [1:0] addr_lsbs);
    return (addr_lsbs == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Request watchdog: clear/enable up-counter whose terminal count flags the
// last allowed REQ cycle without a memory response.
module fetch_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
  localparam logic [W-1:0] MAX  = W'(TIMEOUT_CYCLES);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end

  // Asserted in the cycle whose increment would reach the limit.
  assign expire = enable && (count == LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// Multicycle fetch sequencer: owns the PC, handshakes with instruction memory
// and hands each fetched word to the PC/IR capture register.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_start,
  input  logic        PCWrite,
  input  logic [31:0] PCNext,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] Instr,
  output logic        IRWrite,
  output logic        fetch_busy,
  output logic        fetch_fault,
  output logic        fault_cause
);

  fetch_state_t state;
  logic [31:0]  pc_q;
  logic [31:0]  pend_pc;
  logic         pend_valid;
  logic [31:0]  eff_pc;
  logic [31:0]  deferred_pc;
  logic         wd_clear;
  logic         wd_en;
  logic         wd_expire;

  assign PC        = pc_q;
  assign imem_addr = pc_q;

  // A write in the same cycle as a start takes effect before the alignment check.
  assign eff_pc = PCWrite ? PCNext : pc_q;

  // On leaving REQ/DONE, the newest buffered write wins, including one arriving this cycle.
  assign deferred_pc = PCWrite ? PCNext : (pend_valid ? pend_pc : pc_q);

  assign wd_clear = (state != F_REQ);
  assign wd_en    = (state == F_REQ) && !imem_ready;

  fetch_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (wd_clear),
    .enable (wd_en),
    .expire (wd_expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= F_IDLE;
      pc_q        <= RESET_PC;
      pend_pc     <= '0;
      pend_valid  <= 1'b0;
      Instr       <= NOP_INSTR;
      IRWrite     <= 1'b0;
      imem_req    <= 1'b0;
      fetch_busy  <= 1'b0;
      fetch_fault <= 1'b0;
      fault_cause <= 1'b0;
    end else begin
      IRWrite <= 1'b0;
      case (state)
        F_IDLE: begin
          if (PCWrite) pc_q <= PCNext;
          if (fetch_start) begin
            if (is_aligned(eff_pc[1:0])) begin
              state      <= F_REQ;
              imem_req   <= 1'b1;
              fetch_busy <= 1'b1;
            end else begin
              state       <= F_FAULT;
              fetch_fault <= 1'b1;
              fault_cause <= FAULT_MISALIGN;
            end
          end
        end
        F_REQ: begin
          if (PCWrite) begin
            pend_pc    <= PCNext;
            pend_valid <= 1'b1;
          end
          if (imem_ready) begin
            Instr    <= imem_rdata;
            IRWrite  <= 1'b1;
            imem_req <= 1'b0;
            state    <= F_DONE;
          end else if (wd_expire) begin
            pc_q        <= deferred_pc;
            pend_valid  <= 1'b0;
            imem_req    <= 1'b0;
            fetch_busy  <= 1'b0;
            fetch_fault <= 1'b1;
            fault_cause <= FAULT_TIMEOUT;
            state       <= F_FAULT;
          end
        end
        F_DONE: begin
          pc_q       <= deferred_pc;
          pend_valid <= 1'b0;
          fetch_busy <= 1'b0;
          state      <= F_IDLE;
        end
        F_FAULT: begin
          if (PCWrite) begin
            pc_q        <= PCNext;
            fetch_fault <= 1'b0;
            fault_cause <= 1'b0;
            state       <= F_IDLE;
          end
        end
        default: begin
          state      <= F_IDLE;
          imem_req   <= 1'b0;
          fetch_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
